// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared types and constants for the pong match controller:
//            FSM state encoding, update-phase indices, score width and a
//            saturating score increment.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int NUM_PH  = 4;

    // Bit positions of the per-frame update strobes, in issue order
    localparam int PH_PADDLE = 0;
    localparam int PH_BALL   = 1;
    localparam int PH_CENTER = 2;
    localparam int PH_CHECK  = 3;

    // Encoding is also the debug value shown on state_o
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    // Add one point but never pass the winning score
    function automatic logic [SCORE_W-1:0] score_inc(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] limit
    );
        return (score >= limit) ? score : score + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_match_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pong_match_ctrl_if
// Purpose  : Bundle of tick/button/miss inputs and phase-strobe, score and
//            status outputs between the match controller and the game top.
// Revision : 1.0 - initial release
// ============================================================================
interface pong_match_ctrl_if;
    import pong_pkg::*;

    logic               tick;
    logic               start;
    logic               miss_left;
    logic               miss_right;
    logic               ph_paddle;
    logic               ph_ball;
    logic               ph_center;
    logic               ph_check;
    logic               ball_reset;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [2:0]         state_o;
    logic               game_over;
    logic               winner;
    logic               overrun;

    // Game top / tick source side
    modport master (
        output tick, start, miss_left, miss_right,
        input  ph_paddle, ph_ball, ph_center, ph_check, ball_reset, serve_dir,
        input  score_p1, score_p2, state_o, game_over, winner, overrun
    );

    // Match controller side
    modport slave (
        input  tick, start, miss_left, miss_right,
        output ph_paddle, ph_ball, ph_center, ph_check, ball_reset, serve_dir,
        output score_p1, score_p2, state_o, game_over, winner, overrun
    );

endinterface
`default_nettype wire

// File: rtl/pong_match_ctrl_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : pong_phase_seq
// Purpose  : One-hot update-phase sequencer. A go pulse launches either the
//            full paddle/ball/center/check train or a single paddle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module pong_phase_seq
    import pong_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              go,
    input  wire logic              full,
    output logic [NUM_PH-1:0]      strobe,
    output logic                   busy
);

    logic [NUM_PH-1:0] phase_q, phase_d;
    logic              full_q, full_d;

    assign busy   = |phase_q;
    assign strobe = phase_q;

    // Launch a new train when idle, otherwise walk the token toward check
    always_comb begin
        phase_d = '0;
        full_d  = full_q;
        if (go && !busy) begin
            phase_d[PH_PADDLE] = 1'b1;
            full_d             = full;
        end else if (full_q) begin
            phase_d = phase_q << 1;
        end
    end

    // Phase token register; reset kills any train in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            full_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            full_q  <= full_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_match_ctrl
// Purpose  : Match scheduler: serve countdown, per-frame phase sequencing,
//            scoring, post-point pause and winner detection.
// Revision : 1.0 - initial release
// ============================================================================
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 90,
    parameter int CNT_W       = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pong_match_ctrl_if.slave   bus
);

    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               serve_dir_q, serve_dir_d;
    logic               winner_q, winner_d;
    logic               overrun_q, overrun_d;
    logic               ball_reset_q, ball_reset_d;
    logic               start_prev_q, start_prev_d;

    logic [NUM_PH-1:0]  seq_strobe;
    logic               seq_busy;
    logic               tick_ok;
    logic               seq_go;
    logic               seq_full;
    logic               start_rise;

    // A tick is only honoured when no phase train is in flight
    assign tick_ok    = bus.tick && !seq_busy;
    assign seq_go     = tick_ok && (state_q != ST_IDLE);
    assign seq_full   = (state_q == ST_PLAY);
    assign start_rise = bus.start && !start_prev_q;

    pong_phase_seq u_seq (
        .clk    (clk),
        .reset  (reset),
        .go     (seq_go),
        .full   (seq_full),
        .strobe (seq_strobe),
        .busy   (seq_busy)
    );

    // Next-state, scoring and countdown decisions
    always_comb begin
        state_d      = state_q;
        score_p1_d   = score_p1_q;
        score_p2_d   = score_p2_q;
        cnt_d        = cnt_q;
        serve_dir_d  = serve_dir_q;
        winner_d     = winner_q;
        overrun_d    = overrun_q | (bus.tick & seq_busy);
        ball_reset_d = 1'b0;
        start_prev_d = bus.start;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_rise) begin
                    state_d      = ST_SERVE;
                    score_p1_d   = '0;
                    score_p2_d   = '0;
                    serve_dir_d  = 1'b1;
                    cnt_d        = SERVE_LOAD;
                    ball_reset_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tick_ok) begin
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_PLAY: begin
                if (seq_strobe[PH_CHECK] && (bus.miss_left || bus.miss_right)) begin
                    state_d = ST_POINT;
                    cnt_d   = POINT_LOAD;
                    if (bus.miss_left && !bus.miss_right) begin
                        score_p2_d  = score_inc(score_p2_q, WIN_VAL);
                        serve_dir_d = 1'b0;
                        if (score_p2_d == WIN_VAL) begin
                            state_d  = ST_GAME_OVER;
                            winner_d = 1'b1;
                        end
                    end else if (bus.miss_right && !bus.miss_left) begin
                        score_p1_d  = score_inc(score_p1_q, WIN_VAL);
                        serve_dir_d = 1'b1;
                        if (score_p1_d == WIN_VAL) begin
                            state_d  = ST_GAME_OVER;
                            winner_d = 1'b0;
                        end
                    end
                end
            end
            ST_POINT: begin
                if (tick_ok) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d      = ST_SERVE;
                        cnt_d        = SERVE_LOAD;
                        ball_reset_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Match state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            score_p1_q   <= '0;
            score_p2_q   <= '0;
            cnt_q        <= '0;
            serve_dir_q  <= 1'b1;
            winner_q     <= 1'b0;
            overrun_q    <= 1'b0;
            ball_reset_q <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            cnt_q        <= cnt_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            overrun_q    <= overrun_d;
            ball_reset_q <= ball_reset_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign bus.ph_paddle  = seq_strobe[PH_PADDLE];
    assign bus.ph_ball    = seq_strobe[PH_BALL];
    assign bus.ph_center  = seq_strobe[PH_CENTER];
    assign bus.ph_check   = seq_strobe[PH_CHECK];
    assign bus.ball_reset = ball_reset_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.score_p1   = score_p1_q;
    assign bus.score_p2   = score_p2_q;
    assign bus.state_o    = state_q;
    assign bus.game_over  = (state_q == ST_GAME_OVER);
    assign bus.winner     = winner_q;
    assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_match_ctrl
// Purpose  : Self-checking bench for pong_match_ctrl with an event-level
//            reference model of the match rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_match_ctrl;

    localparam int WIN   = 7;
    localparam int SERVE = 60;
    localparam int POINT = 90;

    logic clk;
    logic reset;

    pong_match_ctrl_if bus();

    pong_match_ctrl #(
        .WIN_SCORE   (WIN),
        .SERVE_TICKS (SERVE),
        .POINT_TICKS (POINT),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: 0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 GAME_OVER
    int cyc      = 0;
    int m_state  = 0;
    int m_s1     = 0;
    int m_s2     = 0;
    int m_cnt    = 0;
    bit m_dir    = 1'b1;
    bit m_win    = 1'b0;
    bit m_over   = 1'b0;
    bit m_brst   = 1'b0;
    bit m_prev   = 1'b0;
    int seq_t0   = -100;   // cycle whose tick launched the last phase train
    bit seq_long = 1'b0;   // that train was the full four-phase one
    int n_matches_won = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_strobes();
        int k;
        int len;
        k   = cyc - seq_t0;
        len = seq_long ? 4 : 1;
        if (k >= 1 && k <= len) return 4'(1 << (k - 1));
        return 4'd0;
    endfunction

    task automatic enter_point();
        m_state = 3;
        m_cnt   = POINT;
    endtask

    // One clock: compare outputs, drive inputs, advance the model
    task automatic step(input logic t, input logic s, input logic ml, input logic mr, input logic rs);
        logic [3:0] es;
        int  k;
        int  old;
        bit  busy;
        bit  chk;
        bit  rise;
        bit  acc;
        bit  go_now;
        @(negedge clk);
        es     = exp_strobes();
        go_now = (m_state == 4);
        check("strobes", {bus.ball_reset, bus.ph_check, bus.ph_center, bus.ph_ball, bus.ph_paddle},
              {m_brst, es});
        check("scores", {bus.score_p1, bus.score_p2}, {4'(m_s1), 4'(m_s2)});
        check("state", bus.state_o, m_state);
        check("flags", {bus.serve_dir, bus.game_over, bus.game_over & bus.winner, bus.overrun},
              {m_dir, go_now, go_now & m_win, m_over});

        bus.tick       = t;
        bus.start      = s;
        bus.miss_left  = ml;
        bus.miss_right = mr;
        reset          = rs;

        if (rs) begin
            m_state = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
            m_dir = 1'b1; m_win = 1'b0; m_over = 1'b0; m_brst = 1'b0; m_prev = 1'b0;
            seq_t0 = -100; seq_long = 1'b0;
        end else begin
            k      = cyc - seq_t0;
            busy   = (k >= 1) && (k <= (seq_long ? 4 : 1));
            chk    = busy && seq_long && (k == 4);
            rise   = s && !m_prev;
            acc    = t && !busy;
            m_prev = s;
            m_brst = 1'b0;
            old    = m_state;
            if (t && busy) m_over = 1'b1;
            if (acc && old != 0) begin
                seq_t0   = cyc;
                seq_long = (old == 2);
            end
            case (old)
                0, 4: if (rise) begin
                    m_state = 1; m_s1 = 0; m_s2 = 0; m_dir = 1'b1;
                    m_cnt = SERVE; m_brst = 1'b1;
                end
                1: if (acc) begin
                    m_cnt--;
                    if (m_cnt == 0) m_state = 2;
                end
                2: if (chk && (ml || mr)) begin
                    if (ml && mr) begin
                        enter_point();
                    end else if (ml) begin
                        m_dir = 1'b0;
                        if (m_s2 < WIN) m_s2++;
                        if (m_s2 == WIN) begin m_state = 4; m_win = 1'b1; n_matches_won++; end
                        else enter_point();
                    end else begin
                        m_dir = 1'b1;
                        if (m_s1 < WIN) m_s1++;
                        if (m_s1 == WIN) begin m_state = 4; m_win = 1'b0; n_matches_won++; end
                        else enter_point();
                    end
                end
                3: if (acc) begin
                    m_cnt--;
                    if (m_cnt == 0) begin m_state = 1; m_cnt = SERVE; m_brst = 1'b1; end
                end
                default: ;
            endcase
        end
        cyc++;
    endtask

    task automatic run_ticks(input int n, input int gap, input logic ml, input logic mr);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, ml, mr, 1'b0);
            for (int j = 1; j < gap; j++) step(1'b0, 1'b0, ml, mr, 1'b0);
        end
    endtask

    initial begin
        logic st;
        int   gap;
        reset = 1'b1; bus.tick = 1'b0; bus.start = 1'b0;
        bus.miss_left = 1'b0; bus.miss_right = 1'b0;

        // Reset state, then ticks in IDLE do nothing
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        run_ticks(2, 6, 1, 1);

        // Start edge, serve countdown into PLAY
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        run_ticks(SERVE, 6, 0, 0);

        // Left miss: P2 scores, pause, serve again
        run_ticks(1, 6, 1, 0);
        run_ticks(POINT, 6, 0, 0);
        run_ticks(SERVE, 6, 0, 0);

        // Double miss: no score, pause
        run_ticks(1, 6, 1, 1);
        run_ticks(POINT, 6, 0, 0);
        run_ticks(SERVE, 6, 0, 0);

        // Tick two cycles after a PLAY tick is dropped and flags overrun
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        run_ticks(2, 6, 0, 0);

        // Randomized play biased toward P1 winning, with occasional restarts
        st  = 1'b0;
        gap = 5;
        for (int i = 0; i < 40000; i++) begin
            logic t;
            t = (gap == 0);
            if (t) gap = ($urandom_range(0, 31) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 7);
            else   gap--;
            if ($urandom_range(0, 199) == 0) st = ~st;
            step(t, st, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 1'b0);
        end
        if (n_matches_won == 0) check("match_reached_game_over", 0, 1);

        // Reset landing on the ph_ball cycle aborts the train
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        run_ticks(SERVE, 6, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level scheduler for the pong game datapath.
- On each game tick it sequences the per-frame update phases in a fixed order: paddle update, ball move, ball centre/edge recompute, collision check.
- It also runs the serve countdown, keeps both players' scores, pauses after each point and declares the winner.
- Sits between the VGA sync/tick source and the ball/paddle object registers in the top level, replacing the free-running update loop.

Parameters:
- WIN_SCORE, 7, points needed to win the match (1..9).
- SERVE_TICKS, 60, ticks the ball is held at centre before play starts.
- POINT_TICKS, 90, ticks of pause after a point before the next serve.
- CNT_W, 8, width of the internal tick down-counter; must hold max(SERVE_TICKS, POINT_TICKS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-cycle game-update pulse (one per frame).
- start  in  1  level from the start button; rising edge is detected internally.
- miss_left  in  1  ball passed the left bound without touching the P1 paddle; valid in the ph_check cycle.
- miss_right  in  1  ball passed the right bound without touching the P2 paddle; valid in the ph_check cycle.
- ph_paddle  out  1  one-cycle strobe: latch paddle positions.
- ph_ball  out  1  one-cycle strobe: advance ball position.
- ph_center  out  1  one-cycle strobe: recompute ball centre and right edge.
- ph_check  out  1  one-cycle strobe: evaluate bounds and collisions.
- ball_reset  out  1  one-cycle strobe: load ball to centre with serve_dir.
- serve_dir  out  1  1 = serve toward +X (P2 side), 0 = toward P1.
- score_p1  out  4  P1 score, 0..WIN_SCORE.
- score_p2  out  4  P2 score, 0..WIN_SCORE.
- state_o  out  3  encoded FSM state for the SSD/LED debug display.
- game_over  out  1  high while in GAME_OVER.
- winner  out  1  0 = P1, 1 = P2; valid only while game_over is high.
- overrun  out  1  sticky: a tick arrived while the phase sequencer was busy.

Behaviour:
- Reset (synchronous): state IDLE, both scores 0, serve_dir 1, counter 0, all strobes 0, game_over 0, winner 0, overrun 0, start edge detector history cleared.
- FSM states: IDLE, SERVE, PLAY, POINT, GAME_OVER.
- IDLE: start rising edge -> SERVE; scores cleared to 0, serve_dir set to 1.
- SERVE:
  - ball_reset pulses in the first cycle of SERVE; counter loads SERVE_TICKS.
  - Each tick decrements the counter.
  - The tick that takes the counter from 1 to 0 moves the FSM to PLAY.
- PLAY:
  - A tick in cycle t, with the sequencer idle, produces ph_paddle at t+1, ph_ball at t+2, ph_center at t+3, ph_check at t+4.
  - The strobes are mutually exclusive, and the sequencer is idle again at t+5.
  - miss_left/miss_right are sampled only on the ph_check cycle. Score and state change at t+5.
- Point resolution:
  - miss_left only: score_p2 +1, serve_dir <= 0.
  - miss_right only: score_p1 +1, serve_dir <= 1.
  - Both in the same check: no score, serve_dir unchanged.
  - After any miss -> POINT, counter loads POINT_TICKS.
  - If an incremented score equals WIN_SCORE -> GAME_OVER instead, with winner set to the scoring player.
- POINT:
  - Each tick decrements the counter; reaching 0 -> SERVE.
  - Only ph_paddle is issued, at t+1, so paddles stay live.
- SERVE also issues ph_paddle on every tick.
- GAME_OVER:
  - Scores frozen, no ball phases issued, ph_paddle still issued on tick.
  - start rising edge -> SERVE with scores cleared and serve_dir 1.
- Busy tick:
  - A tick while the phase sequencer is busy (t+1..t+4) is dropped and sets overrun.
  - overrun is cleared only by reset.
- start is ignored in SERVE, PLAY and POINT.
- Reset mid-sequence: strobes are low from the next cycle and no partial phase completes.
- Score arithmetic: 4-bit unsigned, saturating at WIN_SCORE, never wraps.
- state_o encoding: IDLE 0, SERVE 1, PLAY 2, POINT 3, GAME_OVER 4.

Decomposition:
- Shared package pong_pkg holds:
  - the state encoding constants;
  - the phase index constants (PH_PADDLE=0..PH_CHECK=3);
  - SCORE_W=4.
- One sub-module, pong_phase_seq:
  - takes a go pulse and a mode (full / paddle-only);
  - emits the one-hot strobe train and a busy flag.
- Start edge detection is inline.

Test Plan:
- Reset, start pulse, 60 ticks: ball_reset 1 cycle after start edge; state_o 1 -> 2 after the 60th tick; no ph_ball before then.
- In PLAY, a tick at cycle t: strobes high at exactly t+1..t+4 in order, each 1 cycle; second tick at t+2 -> dropped and overrun=1.
- miss_left on ph_check: score_p2 0 -> 1, serve_dir 0, state POINT; after 90 ticks -> SERVE with ball_reset.
- miss_left and miss_right together: scores unchanged, state POINT, serve_dir unchanged.
- Drive P1 to 6, then miss_right: score_p1=7, game_over=1, winner=0; further misses and ticks leave scores at 7/x; start edge -> scores 0, state SERVE.
- Reset asserted on the ph_ball cycle: no ph_center/ph_check afterwards, all outputs return to reset values next cycle.
